// File: rtl/spram_ctrl_pkg.sv
// Shared types and default geometry for the spram_ctrl request sequencer.
package spram_ctrl_pkg;

  localparam int SPRAM_DATA_W = 8;
  localparam int SPRAM_ADDR_W = 8;
  localparam logic [SPRAM_DATA_W-1:0] SPRAM_CLEAR_VALUE = 8'h00;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/spram_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and spram_ctrl (slave).
interface spram_ctrl_if
  import spram_ctrl_pkg::*;
#(
  parameter int DATA_W = SPRAM_DATA_W,
  parameter int ADDR_W = SPRAM_ADDR_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/single_port_ram.sv
// Synchronous single-port RAM: write on the clock edge, read data one clock after the address edge.
module single_port_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] address,
  input  logic              wr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr_q;

  // NOTE: the storage array has no reset; clearing a RAM takes one write per word,
  // which is exactly what the controller's sweep engine is for.
  always_ff @(posedge clk) begin
    if (wr) mem[address] <= data;
    addr_q <= address;
  end

  assign q = mem[addr_q];

endmodule

// File: rtl/spram_ctrl.sv
// Registers valid/ready requests onto a single_port_ram port and returns read data 2 cycles later.
// Optional fill sweep built only when SPRAM_CTRL_CLEAR_EN is defined.
module spram_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int                DATA_W      = SPRAM_DATA_W,
  parameter int                ADDR_W      = SPRAM_ADDR_W,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(SPRAM_CLEAR_VALUE)
) (
  input  logic              clk,
  input  logic              rst_n,
  spram_ctrl_if.slave       bus,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_q
);

  logic              ready;
  logic              accept;
  logic              sweep;
  logic [ADDR_W-1:0] sweep_addr;
  logic              rd_p1;
  logic              rd_p2;

`ifdef SPRAM_CTRL_CLEAR_EN
  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              sweep_last;

  assign sweep_last = (sweep_cnt == {ADDR_W{1'b1}});
  assign sweep_addr = sweep_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sweep_cnt  <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      clear_done <= (state == ST_CLEAR) && sweep_last;
      // Counter wraps back to 0 after the last address, ready for the next sweep.
      if (state == ST_CLEAR) sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    clear_busy = 1'b0;
    sweep      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (clear_start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        clear_busy = 1'b1;
        sweep      = 1'b1;
        if (sweep_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end
`else
  logic unused_clear_start;

  assign unused_clear_start = clear_start;
  assign ready              = 1'b1;
  assign clear_busy         = 1'b0;
  assign clear_done         = 1'b0;
  assign sweep              = 1'b0;
  assign sweep_addr         = '0;
`endif

  assign bus.req_ready = ready;
  assign accept        = bus.req_valid & ready;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_address <= '0;
      ram_data    <= '0;
      ram_wr      <= 1'b0;
    end else if (sweep) begin
      ram_address <= sweep_addr;
      ram_data    <= CLEAR_VALUE;
      ram_wr      <= 1'b1;
    end else if (accept) begin
      ram_address <= bus.req_addr;
      ram_data    <= bus.req_wr ? bus.req_wdata : '0;
      ram_wr      <= bus.req_wr;
    end else begin
      ram_wr      <= 1'b0;
    end
  end

  // Read tags: stage 1 marks the port load, stage 2 the RAM registering q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1         <= 1'b0;
      rd_p2         <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      rd_p1         <= accept & ~bus.req_wr;
      rd_p2         <= rd_p1;
      bus.rsp_valid <= rd_p2;
      if (rd_p2) bus.rsp_data <= ram_q;
    end
  end

endmodule
